// File: rtl/instr_fetch_decode_if.sv
// Instruction memory fetch interface for instr_fetch_decode.
// Master (fetch stage) drives req/addr; slave (memory) returns rdata/valid.
interface instr_fetch_decode_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch + decode stage: fetches 16-bit words, registers decoded controls.
// Ports: clk, reset_n, imem (fetch bus), stall/flush/flush_pc, decoded outputs.
module instr_fetch_decode #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    instr_fetch_decode_if.master        imem,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [11:0]                 flush_pc,
    output logic                        write,
    output logic [3:0]                  writeReg,
    output logic [3:0]                  readReg0,
    output logic [3:0]                  readReg1,
    output logic [1:0]                  regToMem,
    output logic                        move,
    output logic                        immediate,
    output logic [1:0]                  quarter,
    output logic [3:0]                  ALU_operation,
    output logic                        ReadMem,
    output logic                        WriteMem,
    output logic [7:0]                  imm8,
    output logic                        valid_out,
    output logic [11:0]                 pc_out
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    typedef struct packed {
        logic       write;
        logic [3:0] write_reg;
        logic [3:0] read_reg0;
        logic [3:0] read_reg1;
        logic [1:0] reg_to_mem;
        logic       move;
        logic       immediate;
        logic [1:0] quarter;
        logic [3:0] alu_op;
        logic       read_mem;
        logic       write_mem;
        logic [7:0] imm8;
        logic       valid;
    } ctl_t;

    logic [0:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [11:0] bufpc_q, bufpc_d;
    ctl_t        ctl_q, ctl_d;
    logic [11:0] pc_out_q, pc_out_d;

    logic        issue;
    logic [15:0] iss_ins;
    logic [11:0] iss_pc;

    function automatic ctl_t decode(input logic [15:0] ins);
        ctl_t       c;
        logic [3:0] op;
        logic [3:0] q;
        op = ins[15:12];
        q  = op - 4'd9;
        c  = '0;
        unique case (1'b1)
            (op == 4'h0): begin
                c.valid = 1'b1;
            end
            (op >= 4'h1 && op <= 4'h7): begin
                c.valid     = 1'b1;
                c.write     = 1'b1;
                c.alu_op    = op;
                c.write_reg = ins[11:8];
                c.read_reg0 = ins[7:4];
                c.read_reg1 = ins[3:0];
            end
            (op == 4'h8): begin
                c.valid     = 1'b1;
                c.write     = 1'b1;
                c.move      = 1'b1;
                c.write_reg = ins[11:8];
                c.read_reg0 = ins[7:4];
            end
            (op >= 4'h9 && op <= 4'hC): begin
                c.valid     = 1'b1;
                c.write     = 1'b1;
                c.immediate = 1'b1;
                c.quarter   = q[1:0];
                c.write_reg = ins[11:8];
                c.imm8      = ins[7:0];
            end
            (op == 4'hD): begin
                c.valid      = 1'b1;
                c.write      = 1'b1;
                c.read_mem   = 1'b1;
                c.reg_to_mem = 2'b01;
                c.write_reg  = ins[11:8];
                c.read_reg0  = ins[7:4];
            end
            (op == 4'hE): begin
                c.valid      = 1'b1;
                c.write_mem  = 1'b1;
                c.reg_to_mem = 2'b10;
                c.read_reg0  = ins[7:4];
                c.read_reg1  = ins[11:8];
            end
            default: begin
                // JMP is resolved here; downstream sees a bubble
                c = '0;
            end
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        bufpc_d  = bufpc_q;
        ctl_d    = ctl_q;
        pc_out_d = pc_out_q;
        issue    = 1'b0;
        iss_ins  = buf_q;
        iss_pc   = bufpc_q;

        if (flush) begin
            pc_d    = flush_pc;
            buf_d   = '0;
            bufpc_d = '0;
            ctl_d   = '0;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (imem.imem_valid && !stall) begin
                issue   = 1'b1;
                iss_ins = imem.imem_rdata;
                iss_pc  = pc_q;
            end else if (imem.imem_valid) begin
                // park the word so the bus can be released while stalled
                buf_d   = imem.imem_rdata;
                bufpc_d = pc_q;
                state_d = HOLD;
            end else if (!stall) begin
                ctl_d = '0;
            end
        end else if (!stall) begin
            issue   = 1'b1;
            state_d = FETCH;
        end

        if (issue) begin
            ctl_d = decode(iss_ins);
            if (iss_ins[15:12] == 4'hF) begin
                pc_d = iss_ins[11:0];
            end else begin
                pc_d     = iss_pc + 12'd1;
                pc_out_d = iss_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            bufpc_q  <= '0;
            ctl_q    <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            bufpc_q  <= bufpc_d;
            ctl_q    <= ctl_d;
            pc_out_q <= pc_out_d;
        end
    end

    // request is gated by reset so it is low throughout reset
    assign imem.imem_req  = reset_n & (state_q == FETCH);
    assign imem.imem_addr = pc_q;

    assign write         = ctl_q.write;
    assign writeReg      = ctl_q.write_reg;
    assign readReg0      = ctl_q.read_reg0;
    assign readReg1      = ctl_q.read_reg1;
    assign regToMem      = ctl_q.reg_to_mem;
    assign move          = ctl_q.move;
    assign immediate     = ctl_q.immediate;
    assign quarter       = ctl_q.quarter;
    assign ALU_operation = ctl_q.alu_op;
    assign ReadMem       = ctl_q.read_mem;
    assign WriteMem      = ctl_q.write_mem;
    assign imm8          = ctl_q.imm8;
    assign valid_out     = ctl_q.valid;
    assign pc_out        = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_instr_fetch_decode;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [11:0] flush_pc;
    logic        write;
    logic [3:0]  writeReg;
    logic [3:0]  readReg0;
    logic [3:0]  readReg1;
    logic [1:0]  regToMem;
    logic        move;
    logic        immediate;
    logic [1:0]  quarter;
    logic [3:0]  ALU_operation;
    logic        ReadMem;
    logic        WriteMem;
    logic [7:0]  imm8;
    logic        valid_out;
    logic [11:0] pc_out;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_decode_if imem_bus ();

    instr_fetch_decode #(.RESET_PC(12'h000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem          (imem_bus.master),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .write         (write),
        .writeReg      (writeReg),
        .readReg0      (readReg0),
        .readReg1      (readReg1),
        .regToMem      (regToMem),
        .move          (move),
        .immediate     (immediate),
        .quarter       (quarter),
        .ALU_operation (ALU_operation),
        .ReadMem       (ReadMem),
        .WriteMem      (WriteMem),
        .imm8          (imm8),
        .valid_out     (valid_out),
        .pc_out        (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bundle order: write,wreg,rr0,rr1,r2m,move,imm,quarter,alu,rdm,wrm,imm8,valid
    function automatic logic [33:0] dut_bundle();
        return {write, writeReg, readReg0, readReg1, regToMem, move,
                immediate, quarter, ALU_operation, ReadMem, WriteMem,
                imm8, valid_out};
    endfunction

    // reference decode derived field-by-field from the opcode table
    function automatic logic [33:0] exp_dec(input logic [15:0] ins);
        int op;
        logic w, mv, im, rm, wm, v;
        logic [3:0] wr, r0, r1, alu;
        logic [1:0] r2m, q;
        logic [7:0] i8;
        op  = int'(ins[15:12]);
        v   = (op != 15);
        w   = (op >= 1 && op <= 13);
        mv  = (op == 8);
        im  = (op >= 9 && op <= 12);
        rm  = (op == 13);
        wm  = (op == 14);
        alu = (op >= 1 && op <= 7) ? 4'(op) : 4'd0;
        q   = im ? 2'(op - 9) : 2'd0;
        r2m = rm ? 2'd1 : (wm ? 2'd2 : 2'd0);
        wr  = w ? ins[11:8] : 4'd0;
        r0  = ((op >= 1 && op <= 8) || rm || wm) ? ins[7:4] : 4'd0;
        r1  = (op >= 1 && op <= 7) ? ins[3:0] : (wm ? ins[11:8] : 4'd0);
        i8  = im ? ins[7:0] : 8'd0;
        return {w, wr, r0, r1, r2m, mv, im, q, alu, rm, wm, i8, v};
    endfunction

    task automatic drive(input logic v, input logic [15:0] rd, input logic st,
                         input logic fl, input logic [11:0] fpc);
        imem_bus.imem_valid = v;
        imem_bus.imem_rdata = rd;
        stall    = st;
        flush    = fl;
        flush_pc = fpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 16'h0;
        stall = 1'b0; flush = 1'b0; flush_pc = 12'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 16'h0;
        stall = 1'b0; flush = 1'b0; flush_pc = 12'h0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({dut_bundle(), pc_out} !== 46'h0) begin
            n_err++; $display("FAIL reset_outs got %h want 0", {dut_bundle(), pc_out});
        end
        n_vec++;
        if (imem_bus.imem_req !== 1'b0) begin
            n_err++; $display("FAIL reset_req got %b want 0", imem_bus.imem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_vec++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 12'h000}) begin
            n_err++; $display("FAIL release_req got %b/%h want 1/000",
                              imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_alu();
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if (dut_bundle() !== {1'b1, 4'h2, 4'h3, 4'h4, 2'b00, 1'b0, 1'b0,
                              2'b00, 4'h1, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            n_err++; $display("FAIL alu_dec got %h", dut_bundle());
        end
        n_vec++;
        if ({pc_out, imem_bus.imem_addr} !== {12'h000, 12'h001}) begin
            n_err++; $display("FAIL alu_pc got %h/%h want 000/001", pc_out, imem_bus.imem_addr);
        end
    endtask

    task automatic test_ldi();
        drive(1'b1, 16'hB5A7, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if (dut_bundle() !== {1'b1, 4'h5, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1,
                              2'b10, 4'h0, 1'b0, 1'b0, 8'hA7, 1'b1}) begin
            n_err++; $display("FAIL ldi_dec got %h", dut_bundle());
        end
        n_vec++;
        if ({pc_out, imem_bus.imem_addr} !== {12'h001, 12'h002}) begin
            n_err++; $display("FAIL ldi_pc got %h/%h want 001/002", pc_out, imem_bus.imem_addr);
        end
    endtask

    task automatic test_stall_store();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 12'h010);
        n_vec++;
        if ({dut_bundle(), imem_bus.imem_addr} !== {34'h0, 12'h010}) begin
            n_err++; $display("FAIL flush_to_010 got %h", {dut_bundle(), imem_bus.imem_addr});
        end
        drive(1'b1, 16'hE215, 1'b1, 1'b0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({dut_bundle(), pc_out, imem_bus.imem_req, imem_bus.imem_addr}
                !== {34'h0, 12'h001, 1'b0, 12'h010}) begin
                n_err++; $display("FAIL hold_%0d got %h/%h req %b addr %h", i,
                                  dut_bundle(), pc_out, imem_bus.imem_req, imem_bus.imem_addr);
            end
            if (i < 2) drive(1'b1, 16'($urandom), 1'b1, 1'b0, 12'h0);
        end
        drive(1'b1, 16'h1999, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if (dut_bundle() !== {1'b0, 4'h0, 4'h1, 4'h2, 2'b10, 1'b0, 1'b0,
                              2'b00, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1}) begin
            n_err++; $display("FAIL store_dec got %h", dut_bundle());
        end
        n_vec++;
        if ({pc_out, imem_bus.imem_req, imem_bus.imem_addr} !== {12'h010, 1'b1, 12'h011}) begin
            n_err++; $display("FAIL store_pc got %h req %b addr %h want 010/1/011",
                              pc_out, imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if (valid_out !== 1'b0) begin
            n_err++; $display("FAIL store_once got valid %b want 0", valid_out);
        end
    endtask

    task automatic test_jmp_wrap();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 12'h005);
        drive(1'b1, 16'hF3C0, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if ({dut_bundle(), pc_out, imem_bus.imem_addr} !== {34'h0, 12'h010, 12'h3C0}) begin
            n_err++; $display("FAIL jmp got %h pc_out %h addr %h want bubble/010/3C0",
                              dut_bundle(), pc_out, imem_bus.imem_addr);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1, 12'hFFF);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if ({dut_bundle(), pc_out, imem_bus.imem_addr} !== {34'h1, 12'hFFF, 12'h000}) begin
            n_err++; $display("FAIL wrap got %h pc_out %h addr %h want 1/FFF/000",
                              dut_bundle(), pc_out, imem_bus.imem_addr);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 12'h200);
        n_vec++;
        if ({dut_bundle(), imem_bus.imem_req, imem_bus.imem_addr} !== {34'h0, 1'b1, 12'h200}) begin
            n_err++; $display("FAIL flush_stall got %h req %b addr %h want 0/1/200",
                              dut_bundle(), imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1'b1, 16'h2345, 1'b1, 1'b0, 12'h0);
        drive(1'b0, 16'h0, 1'b1, 1'b1, 12'h300);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if ({dut_bundle(), imem_bus.imem_req, imem_bus.imem_addr} !== {34'h0, 1'b1, 12'h300}) begin
            n_err++; $display("FAIL flush_hold got %h req %b addr %h want 0/1/300",
                              dut_bundle(), imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 12'h0);
        drive(1'b1, 16'h5678, 1'b1, 1'b0, 12'h0);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({dut_bundle(), pc_out, imem_bus.imem_req} !== 47'h0) begin
            n_err++; $display("FAIL rst_hold got %h pc_out %h req %b want 0",
                              dut_bundle(), pc_out, imem_bus.imem_req);
        end
        stall = 1'b0;
        imem_bus.imem_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_vec++;
        if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 12'h000}) begin
            n_err++; $display("FAIL rst_hold_rel got %b/%h want 1/000",
                              imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
        n_vec++;
        if ({dut_bundle(), pc_out, imem_bus.imem_addr} !== 58'h0) begin
            n_err++; $display("FAIL rst_hold_nopulse got %h pc_out %h addr %h want 0",
                              dut_bundle(), pc_out, imem_bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic [11:0] m_pc, m_bpc, m_pcout;
        logic [15:0] m_buf, ins;
        logic [33:0] m_out;
        logic        m_hold, v, st, fl, go;
        logic [11:0] fpc, ipc;
        do_reset();
        m_pc = 12'h000; m_bpc = '0; m_pcout = '0;
        m_buf = '0; m_out = '0; m_hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(3) != 0);
            st  = ($urandom_range(3) == 0);
            fl  = ($urandom_range(19) == 0);
            fpc = 12'($urandom);
            ins = 16'($urandom);
            drive(v, ins, st, fl, fpc);
            go = 1'b0; ipc = m_pc;
            if (fl) begin
                m_pc = fpc; m_hold = 1'b0; m_out = '0;
            end else if (m_hold) begin
                if (!st) begin go = 1'b1; ins = m_buf; ipc = m_bpc; m_hold = 1'b0; end
            end else if (v && st) begin
                m_buf = ins; m_bpc = m_pc; m_hold = 1'b1;
            end else if (v) begin
                go = 1'b1;
            end else if (!st) begin
                m_out = '0;
            end
            if (go) begin
                m_out = exp_dec(ins);
                if (ins[15:12] == 4'hF) m_pc = ins[11:0];
                else begin m_pcout = ipc; m_pc = ipc + 12'd1; end
            end
            n_vec++;
            if ({dut_bundle(), pc_out, imem_bus.imem_req, imem_bus.imem_addr}
                !== {m_out, m_pcout, ~m_hold, m_pc}) begin
                n_err++;
                $display("FAIL rand_%0d got %h/%h/%b/%h want %h/%h/%b/%h", c,
                         dut_bundle(), pc_out, imem_bus.imem_req, imem_bus.imem_addr,
                         m_out, m_pcout, ~m_hold, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ldi();
        test_stall_store();
        test_jmp_wrap();
        test_flush();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and reset_n.
REQ-002 Parameter: RESET_PC, default 12'h000, PC value loaded on reset.
REQ-003 clk  in  1  rising-edge clock for all state and output registers.
REQ-004 reset_n  in  1  async active-low reset.
REQ-005 imem_req  out  1  fetch request; imem_addr  out  12  word address (= pc).
REQ-006 imem_rdata  in  16  instruction word; imem_valid  in  1  rdata valid; sampled only while imem_req=1.
REQ-007 stall  in  1  downstream hazard hold; flush  in  1  redirect; flush_pc  in  12  redirect target.
REQ-008 Decoded outputs, all registered: write 1, writeReg 4, readReg0 4, readReg1 4, regToMem 2, move 1, immediate 1, quarter 2, ALU_operation 4, ReadMem 1, WriteMem 1, imm8 8, valid_out 1, pc_out 12.

Function
REQ-009 Instruction format: op=[15:12], rd=[11:8], rs0=[7:4], rs1=[3:0], imm8=[7:0], target=[11:0].
REQ-010 Decode table; unlisted fields 0:
- op 0: NOP; all controls 0, valid_out=1.
- op 1-7: ALU; write=1, ALU_operation=op, writeReg=rd, readReg0=rs0, readReg1=rs1.
- op 8: MOV; write=1, move=1, writeReg=rd, readReg0=rs0.
- op 9-C: LDI; write=1, immediate=1, quarter=op-9, writeReg=rd, imm8=imm8.
- op D: LOAD; write=1, ReadMem=1, regToMem=01, writeReg=rd, readReg0=rs0.
- op E: STORE; WriteMem=1, regToMem=10, readReg0=rs0 (address), readReg1=rd (data).
- op F: JMP; consumed in this stage; issues bubble.
REQ-011 Bubble = all controls, imm8, valid_out = 0; pc_out holds its last value.
REQ-012 FSM states FETCH, HOLD; reset state FETCH.
REQ-013 FETCH: imem_req=1, imem_addr=pc; HOLD: imem_req=0, imem_addr=pc.
REQ-014 FETCH, imem_valid=1, stall=0: next edge registers decode of imem_rdata, pc_out=pc, pc<=pc+1 (JMP: pc<=target, bubble); stay FETCH.
REQ-015 FETCH, imem_valid=1, stall=1: capture imem_rdata and pc in hold buffer; outputs hold; pc unchanged; ->HOLD.
REQ-016 FETCH, imem_valid=0: stall=0 -> bubble; stall=1 -> outputs hold; pc unchanged.
REQ-017 HOLD, stall=1: everything holds; HOLD, stall=0: issue buffered instruction per REQ-014 (pc update included), ->FETCH.
REQ-018 Latency: instruction accepted at edge N appears on outputs after edge N; one instruction per cycle at full rate.
REQ-019 flush=1 has priority over all else: pc<=flush_pc, hold buffer discarded, outputs bubble, ->FETCH; same-cycle imem_valid ignored; applies even with stall=1.
REQ-020 pc is 12-bit, wraps 12'hFFF -> 12'h000; JMP to own address is legal (spins).
REQ-021 imem_addr is stable while in FETCH awaiting imem_valid, except on flush.

Reset
REQ-022 reset_n=0 asynchronously: pc=RESET_PC, state FETCH, hold buffer 0, every decoded output and valid_out 0, pc_out 0.
REQ-023 imem_req is 0 while reset_n=0, 1 on the first cycle after release.
REQ-024 Reset mid-HOLD or mid-fetch discards the pending instruction; no output pulse on release.

Verification
REQ-025 Reset release, imem_valid=1 each cycle, rdata 0x1234 at 0x000 -> after edge 1: write=1, ALU_operation=1, writeReg=2, readReg0=3, readReg1=4, pc_out=0x000; imem_addr=0x001.
REQ-026 rdata 0xB5A7 -> immediate=1, quarter=2, writeReg=5, imm8=0xA7, write=1.
REQ-027 0xE21x at pc 0x010 with stall=1 for 3 cycles -> outputs hold, imem_req=0 in HOLD; on stall release STORE issues once (WriteMem=1, regToMem=10, readReg0=1, readReg1=2), next imem_addr=0x011.
REQ-028 0xF3C0 at pc 0x005 -> bubble, imem_addr=0x3C0 next cycle; pc 0xFFF non-jump -> next imem_addr=0x000.
REQ-029 flush=1, flush_pc=0x200, concurrent with stall=1 and imem_valid=1 -> bubble, instruction dropped, imem_addr=0x200, FETCH.
REQ-030 Assert reset_n=0 during HOLD -> all outputs 0 immediately; after release fetch starts at RESET_PC, buffered instruction never issued.
